// File: rtl/mux4_feed_pkg.sv
// Shared widths and the channel index type for the 4-channel mux feeder.
package mux4_feed_pkg;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/mux4_feed_sched_rr_pick4.sv
// Combinational round-robin picker: first set bit of cand at or after ptr, modulo 4.
module rr_pick4
    import mux4_feed_pkg::*;
(
    input  logic [3:0] cand,
    input  ch_idx_t    ptr,
    output logic       found,
    output ch_idx_t    idx
);
    ch_idx_t w_pos;

    // Walk from the farthest offset back to ptr so the nearest candidate wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        w_pos = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_pos = ptr + ch_idx_t'(k);
            if (cand[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end
endmodule

// File: rtl/mux4_feed_sched.sv
// Feeds a 4-to-1 output mux from four one-entry channel buffers with a
// registered round-robin grant (sel/en) paced by the downstream out_ready.
module mux4_feed_sched
    import mux4_feed_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    src_valid,
    input  logic [DATA_W-1:0]    src_data0,
    input  logic [DATA_W-1:0]    src_data1,
    input  logic [DATA_W-1:0]    src_data2,
    input  logic [DATA_W-1:0]    src_data3,
    output logic [NUM_CH-1:0]    src_ready,
    output logic [DATA_W-1:0]    buf_data0,
    output logic [DATA_W-1:0]    buf_data1,
    output logic [DATA_W-1:0]    buf_data2,
    output logic [DATA_W-1:0]    buf_data3,
    output logic [1:0]           sel,
    output logic                 en,
    input  logic                 out_ready
);
    logic [DATA_W-1:0] w_src_data [NUM_CH];
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_cap;
    logic [NUM_CH-1:0] w_cand;
    logic              w_xfer;
    logic              w_decide;
    logic              w_found;
    ch_idx_t           w_idx;
    ch_idx_t           w_start;
    ch_idx_t           w_sel_inc;
    ch_idx_t           r_sel;
    ch_idx_t           r_ptr;
    logic              r_en;

    assign w_src_data[0] = src_data0;
    assign w_src_data[1] = src_data1;
    assign w_src_data[2] = src_data2;
    assign w_src_data[3] = src_data3;

    assign w_xfer    = r_en & out_ready;
    assign w_decide  = ~r_en | out_ready;
    assign w_sel_inc = r_sel + 2'd1;
    assign w_start   = w_xfer ? w_sel_inc : r_ptr;
    // A word captured this cycle only becomes visible to the picker next cycle.
    assign w_cand    = w_full & ~w_pop;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              r_full;
        logic [DATA_W-1:0] r_buf;

        assign w_pop[i]     = w_xfer & (r_sel == ch_idx_t'(i));
        assign src_ready[i] = ~r_full | w_pop[i];
        assign w_cap[i]     = src_valid[i] & src_ready[i];
        assign w_full[i]    = r_full;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_full <= 1'b0;
                r_buf  <= '0;
            end else if (w_cap[i]) begin
                r_full <= 1'b1;
                r_buf  <= w_src_data[i];
            end else if (w_pop[i]) begin
                r_full <= 1'b0;
            end
        end
    end

    assign buf_data0 = g_ch[0].r_buf;
    assign buf_data1 = g_ch[1].r_buf;
    assign buf_data2 = g_ch[2].r_buf;
    assign buf_data3 = g_ch[3].r_buf;

    rr_pick4 u_pick (
        .cand  (w_cand),
        .ptr   (w_start),
        .found (w_found),
        .idx   (w_idx)
    );

    // Grant only changes when the current word is accepted or nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
            r_ptr <= '0;
            r_en  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_ptr <= w_sel_inc;
            end
            if (w_decide) begin
                if (w_found) begin
                    r_sel <= w_idx;
                    r_en  <= 1'b1;
                end else begin
                    r_en  <= 1'b0;
                end
            end
        end
    end

    assign sel = r_sel;
    assign en  = r_en;
endmodule

// File: tb/tb_mux4_feed_sched.sv
// Directed-vector bench for mux4_feed_sched; inputs change and outputs are sampled on the falling edge.
module tb_mux4_feed_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src_valid = 4'h0;
    logic [31:0] src_data [4];
    logic [3:0]  src_ready;
    logic [31:0] buf_data0, buf_data1, buf_data2, buf_data3;
    logic [1:0]  sel;
    logic        en;
    logic        out_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux4_feed_sched dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_data0 (src_data[0]),
        .src_data1 (src_data[1]),
        .src_data2 (src_data[2]),
        .src_data3 (src_data[3]),
        .src_ready (src_ready),
        .buf_data0 (buf_data0),
        .buf_data1 (buf_data1),
        .buf_data2 (buf_data2),
        .buf_data3 (buf_data3),
        .sel       (sel),
        .en        (en),
        .out_ready (out_ready)
    );

    function automatic logic [31:0] buf_at(input logic [1:0] k);
        case (k)
            2'd0:    return buf_data0;
            2'd1:    return buf_data1;
            2'd2:    return buf_data2;
            default: return buf_data3;
        endcase
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = 4'h0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        src_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) src_data[i] = 32'h1234_5670 + i;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %0b want 0", en); end
            n_cmp++;
            if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel); end
            n_cmp++;
            if ({buf_data0, buf_data1, buf_data2, buf_data3} !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_buf: got %h %h %h %h want all 0", buf_data0, buf_data1, buf_data2, buf_data3);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (src_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %h want f", src_ready); end
        src_valid = 4'h0;
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready   = 1'b1;
        src_valid   = 4'b0100;
        src_data[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        src_valid = 4'h0;
        #1;
        n_cmp++;
        if (buf_data2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_capture: got %h want deadbeef", buf_data2); end
        n_cmp++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL single_no_early_grant: got en=%0b want 0", en); end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({en, sel} !== 3'b110) begin n_fail++; $display("FAIL single_grant: got en=%0b sel=%0d want en=1 sel=2", en, sel); end
        n_cmp++;
        if (buf_data2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_present: got %h want deadbeef", buf_data2); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL single_drain: got en=%0b want 0", en); end
        n_cmp++;
        if (dut.r_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", dut.r_ptr); end
        n_cmp++;
        if (dut.w_full !== 4'h0) begin n_fail++; $display("FAIL single_full: got %h want 0", dut.w_full); end
    endtask

    task automatic test_round_robin();
        int          cnt [4];
        int          exp_cnt [4];
        logic [1:0]  exp_sel;
        logic [31:0] exp_word;
        do_reset();
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; exp_cnt[i] = 0; end
        exp_sel   = 2'd0;
        out_ready = 1'b1;
        src_valid = 4'hF;
        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < 4; i++) src_data[i] = 32'hA0 + i + (cnt[i] << 8);
            #1;
            if (it >= 2) begin
                n_cmp++;
                if (en !== 1'b1) begin n_fail++; $display("FAIL rr_en it=%0d: got %0b want 1", it, en); end
            end
            if (en === 1'b1) begin
                exp_word = 32'hA0 + exp_sel + (exp_cnt[exp_sel] << 8);
                n_cmp++;
                if (sel !== exp_sel) begin n_fail++; $display("FAIL rr_sel it=%0d: got %0d want %0d", it, sel, exp_sel); end
                n_cmp++;
                if (buf_at(exp_sel) !== exp_word) begin
                    n_fail++;
                    $display("FAIL rr_word it=%0d ch=%0d: got %h want %h", it, exp_sel, buf_at(exp_sel), exp_word);
                end
                exp_cnt[exp_sel]++;
                exp_sel = exp_sel + 2'd1;
            end
            for (int i = 0; i < 4; i++) if (src_valid[i] && src_ready[i]) cnt[i]++;
            @(negedge clk);
        end
        src_valid = 4'h0;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready   = 1'b0;
        src_valid   = 4'b1010;
        src_data[1] = 32'h1111_0001;
        src_data[3] = 32'h3333_0003;
        @(negedge clk);
        src_valid = 4'h0;
        @(negedge clk);
        // A competing word on ch1 must be refused while its buffer is held.
        src_valid   = 4'b0010;
        src_data[1] = 32'hBAD0_0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({en, sel} !== 3'b101) begin n_fail++; $display("FAIL bp_hold c=%0d: got en=%0b sel=%0d want en=1 sel=1", c, en, sel); end
            n_cmp++;
            if (buf_data1 !== 32'h1111_0001) begin n_fail++; $display("FAIL bp_buf c=%0d: got %h want 11110001", c, buf_data1); end
            n_cmp++;
            if (src_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready c=%0d: got %0b want 0", c, src_ready[1]); end
            @(negedge clk);
        end
        src_valid = 4'h0;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({en, sel} !== 3'b101) begin n_fail++; $display("FAIL bp_release: got en=%0b sel=%0d want en=1 sel=1", en, sel); end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({en, sel} !== 3'b111) begin n_fail++; $display("FAIL bp_next: got en=%0b sel=%0d want en=1 sel=3", en, sel); end
        n_cmp++;
        if (buf_data3 !== 32'h3333_0003) begin n_fail++; $display("FAIL bp_word3: got %h want 33330003", buf_data3); end
        n_cmp++;
        if (dut.w_full !== 4'b1000) begin n_fail++; $display("FAIL bp_full: got %h want 8", dut.w_full); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got en=%0b want 0", en); end
    endtask

    task automatic test_pop_refill();
        logic [31:0] next_word;
        logic [31:0] exp_word;
        logic        exp_en;
        do_reset();
        next_word = 32'd0;
        exp_word  = 32'd0;
        out_ready = 1'b1;
        src_valid = 4'b0001;
        for (int it = 0; it < 10; it++) begin
            src_data[0] = next_word;
            #1;
            exp_en = (it >= 2) && (it % 2 == 0);
            n_cmp++;
            if (en !== exp_en) begin n_fail++; $display("FAIL refill_en it=%0d: got %0b want %0b", it, en, exp_en); end
            if (en === 1'b1) begin
                n_cmp++;
                if (buf_data0 !== exp_word) begin n_fail++; $display("FAIL refill_word it=%0d: got %0d want %0d", it, buf_data0, exp_word); end
                exp_word++;
            end
            if (src_ready[0] === 1'b1) next_word++;
            @(negedge clk);
        end
        n_cmp++;
        if (exp_word !== 32'd4) begin n_fail++; $display("FAIL refill_count: got %0d words want 4", exp_word); end
        src_valid = 4'h0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready   = 1'b0;
        src_valid   = 4'b1000;
        src_data[3] = 32'h5757_0003;
        @(negedge clk);
        src_valid = 4'h0;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({en, sel} !== 3'b111) begin n_fail++; $display("FAIL mid_stall_grant: got en=%0b sel=%0d want en=1 sel=3", en, sel); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_en: got %0b want 0", en); end
        n_cmp++;
        if (dut.w_full !== 4'h0) begin n_fail++; $display("FAIL mid_rst_full: got %h want 0", dut.w_full); end
        n_cmp++;
        if (dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL mid_rst_ptr: got %0d want 0", dut.r_ptr); end
        n_cmp++;
        if (buf_data3 !== 32'h0) begin n_fail++; $display("FAIL mid_rst_buf3: got %h want 0", buf_data3); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_replay c=%0d: got en=%0b want 0", c, en); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) src_data[i] = 32'h0;
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_pop_refill();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mux4_feed_sched.md
# mux4_feed_sched

Upstream feeder for the 32-bit 4-to-1 tristate output mux. It accepts words from four independent producer channels over valid/ready handshakes and holds each word in a one-entry per-channel buffer. It drives the mux data inputs from those buffers and drives the mux `sel`/`en` from a registered round-robin grant. A downstream valid/ready handshake on the mux output paces the grants.

## Interface
- `DATA_W`, 32: word width; fixed to match the mux data width.
- `NUM_CH`, 4: channel count; fixed at 4 because `sel` is 2 bits.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `src_valid`  in  4  producer i presents a word.
- `src_data0`..`src_data3`  in  32 each  producer words.
- `src_ready`  out  4  channel i buffer can accept this cycle.
- `buf_data0`..`buf_data3`  out  32 each  buffered words; connect to mux `in1`..`in4`.
- `sel`  out  2  registered grant index; connect to mux `sel`.
- `en`  out  1  registered grant valid; connect to mux `en`. Also acts as output-valid.
- `out_ready`  in  1  consumer of the mux output accepts the word this cycle.

## Operation
- **Per-channel buffer.** Each channel i has a `full[i]` flag and a 32-bit register.
  - `pop[i]` = `en & out_ready & (sel == i)`.
  - `src_ready[i]` = `~full[i] | pop[i]`.
  - Capture `src_data_i` when `src_valid[i] & src_ready[i]`; `full[i]` is set next cycle.
  - A pop with a same-cycle capture leaves `full[i]` = 1 holding the new word.
  - A pop without a capture clears `full[i]`.
- **Buffer stability.** `buf_data_i` changes only on capture. It is stable whenever `full[i]` = 1 and not popped.
- **Arbitration.** `ptr[1:0]` is the round-robin start point.
  - Decision point: a cycle with `~en | out_ready`. Grant state is held in all other cycles.
  - Candidates = `full` with the popped bit cleared. Words captured this cycle are not candidates.
  - Search order is `ptr`, `ptr+1`, … modulo 4, where the effective ptr is `sel+1` if a pop occurs this cycle, else `ptr`.
  - First candidate found: `sel` ← index, `en` ← 1. No candidate: `en` ← 0 and `sel` holds its value.
  - On a pop, `ptr` ← `sel+1`, wrapping 3→0.
- **Stall.** While `en`=1 and `out_ready`=0, `sel`, `en` and `buf_data[sel]` are all frozen. The mux output is therefore stable until accepted.

## Timing
- **Reset values:** `full`=0, `ptr`=0, `sel`=0, `en`=0, all `buf_data`=0. `src_ready`=4'b1111 in the first cycle after reset.
- **Latency:** a word captured at edge N is granted (`en`=1) at edge N+1 at the earliest. It transfers in the first cycle with `out_ready`=1.
- **Throughput:**
  - 1 word/cycle when at least two channels are continuously full.
  - A single continuously-fed channel achieves 1 word per 2 cycles. This is intentional: a refill is not a same-cycle candidate.
- **Reset mid-operation:** buffered and granted words are discarded. There is no partial-state carryover.
- `rst` has priority over every capture and pop in the same cycle.

## Structure
- Package `mux4_feed_pkg`:
  - `DATA_W`=32 and `NUM_CH`=4.
  - Typedef `ch_idx_t` (logic [1:0]).
- Sub-module `rr_pick4`: purely combinational.
  - Inputs: 4-bit candidate vector and 2-bit start pointer.
  - Outputs: `found` and `idx`.
  - Instantiated once.
- Top: four buffer slices (generate loop), grant/pointer registers, handshake logic.

## Test plan
- **Reset:** hold `rst` 2 cycles with `src_valid`=4'hF.
  - During reset: `en`=0, `sel`=0, all `buf_data`=0.
  - After release: `src_ready`=4'hF.
- **Single word:** `src_valid[2]`=1, data 32'hDEAD_BEEF for 1 cycle, `out_ready`=1.
  - Next cycle: `en`=1, `sel`=2, `buf_data2`=32'hDEAD_BEEF.
  - Cycle after: `en`=0, `ptr`=3.
- **Round-robin fairness:** all four channels fed continuously with tags 0xA0+i, `out_ready`=1.
  - Grant sequence `sel`=0,1,2,3,0,1… with `en`=1 every cycle.
  - Each tag appears in order per channel.
- **Backpressure:** ch1 and ch3 full, `out_ready`=0 for 5 cycles.
  - `sel`=1, `en`=1 and `buf_data1` frozen for all 5 cycles; `src_ready[1]`=0.
  - On release: transfer, then `sel`=3.
- **Same-cycle pop and refill:** ch0 only, `src_valid[0]`=1 continuously, data incrementing from 0, `out_ready`=1.
  - `en` toggles 1,0,1,0.
  - Words 0,1,2… are accepted with no loss or duplication.
- **Reset mid-stall:** `en`=1, `sel`=3, `out_ready`=0, then assert `rst` for 1 cycle.
  - Next cycle: `en`=0, `full`=0, `ptr`=0.
  - The stalled word is never presented again.
